link_list_sram: RTL and testbench

- Next-pointer store for the switch's packet-buffer linked lists.
- Each entry holds the address of the next cell in a chain: 2^ADDR_LENTH entries, each ADDR_LENTH bits wide.
- Ports: four independent write ports (one per ingress port), four read ports (one per egress port), and one drop-read port used by the discard path.
- Sits between the buffer manager/free-list logic and the per-port queue walkers.

---
 rtl/link_list_sram_pkg.sv | 9 +
 rtl/link_list_rd_port.sv | 32 +++
 rtl/link_list_sram.sv | 128 ++++++++++++
 tb/tb_link_list_sram.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/link_list_sram_pkg.sv
// rtl/link_list_sram_pkg.sv - shared constants and types for the next-pointer store
package link_list_sram_pkg;

  localparam int LL_ADDR_LENTH = 12;
  localparam int NUM_PORTS     = 4;

  typedef logic [LL_ADDR_LENTH-1:0] cell_addr_t;

endpackage

// File: rtl/link_list_rd_port.sv
// rtl/link_list_rd_port.sv - registered single-cycle read stage for one lookup port
module link_list_rd_port
  import link_list_sram_pkg::*;
#(
  parameter int WIDTH = LL_ADDR_LENTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] lookup_addr,
  input  logic [WIDTH-1:0] lookup_data,
  output logic [WIDTH-1:0] data,
  output logic             vld
);

  assign lookup_addr = addr;

  // capture the addressed entry on request; data holds its last value otherwise
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data <= '0;
      vld  <= 1'b0;
    end else begin
      vld <= req;
      if (req) begin
        data <= lookup_data;
      end
    end
  end

endmodule

// File: rtl/link_list_sram.sv
// rtl/link_list_sram.sv - next-pointer store with 4 write ports and 5 registered read ports
module link_list_sram
  import link_list_sram_pkg::*;
#(
  parameter int ADDR_LENTH = LL_ADDR_LENTH
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [ADDR_LENTH-1:0] iWriteLdata0,
  input  logic [ADDR_LENTH-1:0] iWriteLaddr0,
  input  logic                  iWriteLaddrVld0,
  input  logic [ADDR_LENTH-1:0] iWriteLdata1,
  input  logic [ADDR_LENTH-1:0] iWriteLaddr1,
  input  logic                  iWriteLaddrVld1,
  input  logic [ADDR_LENTH-1:0] iWriteLdata2,
  input  logic [ADDR_LENTH-1:0] iWriteLaddr2,
  input  logic                  iWriteLaddrVld2,
  input  logic [ADDR_LENTH-1:0] iWriteLdata3,
  input  logic [ADDR_LENTH-1:0] iWriteLaddr3,
  input  logic                  iWriteLaddrVld3,
  output logic [ADDR_LENTH-1:0] oLdata0,
  output logic                  oLdataVld0,
  input  logic [ADDR_LENTH-1:0] iLaddr0,
  input  logic                  iLNxtAddrReq0,
  output logic [ADDR_LENTH-1:0] oLdata1,
  output logic                  oLdataVld1,
  input  logic [ADDR_LENTH-1:0] iLaddr1,
  input  logic                  iLNxtAddrReq1,
  output logic [ADDR_LENTH-1:0] oLdata2,
  output logic                  oLdataVld2,
  input  logic [ADDR_LENTH-1:0] iLaddr2,
  input  logic                  iLNxtAddrReq2,
  output logic [ADDR_LENTH-1:0] oLdata3,
  output logic                  oLdataVld3,
  input  logic [ADDR_LENTH-1:0] iLaddr3,
  input  logic                  iLNxtAddrReq3,
  input  logic [ADDR_LENTH-1:0] iDropAddr,
  input  logic                  iDropAddrVld,
  output logic [ADDR_LENTH-1:0] oDropData,
  output logic                  oDropDataVld
);

  localparam int DEPTH  = 1 << ADDR_LENTH;
  localparam int NUM_RD = NUM_PORTS + 1;

  // Entries are cleared logically: a per-entry live bit is zeroed on reset and
  // entries whose bit is clear read as 0, so the array itself needs no reset.
  logic [ADDR_LENTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      live;

  logic [NUM_PORTS-1:0]  wr_vld;
  logic [ADDR_LENTH-1:0] wr_addr [NUM_PORTS];
  logic [ADDR_LENTH-1:0] wr_data [NUM_PORTS];

  logic                  rd_req  [NUM_RD];
  logic [ADDR_LENTH-1:0] rd_addr [NUM_RD];
  logic [ADDR_LENTH-1:0] lu_addr [NUM_RD];
  logic [ADDR_LENTH-1:0] lu_data [NUM_RD];
  logic [ADDR_LENTH-1:0] rd_data [NUM_RD];
  logic                  rd_vld  [NUM_RD];

  assign wr_vld     = {iWriteLaddrVld3, iWriteLaddrVld2, iWriteLaddrVld1, iWriteLaddrVld0};
  assign wr_addr[0] = iWriteLaddr0;
  assign wr_addr[1] = iWriteLaddr1;
  assign wr_addr[2] = iWriteLaddr2;
  assign wr_addr[3] = iWriteLaddr3;
  assign wr_data[0] = iWriteLdata0;
  assign wr_data[1] = iWriteLdata1;
  assign wr_data[2] = iWriteLdata2;
  assign wr_data[3] = iWriteLdata3;

  // later statements win, so port 0 is applied last and takes address collisions
  always_ff @(posedge iClk) begin
    if (wr_vld[3]) mem[wr_addr[3]] <= wr_data[3];
    if (wr_vld[2]) mem[wr_addr[2]] <= wr_data[2];
    if (wr_vld[1]) mem[wr_addr[1]] <= wr_data[1];
    if (wr_vld[0]) mem[wr_addr[0]] <= wr_data[0];
  end

  // live bits follow the writes and are wiped by reset
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      live <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_vld[p]) live[wr_addr[p]] <= 1'b1;
      end
    end
  end

  assign rd_req[0]  = iLNxtAddrReq0;
  assign rd_req[1]  = iLNxtAddrReq1;
  assign rd_req[2]  = iLNxtAddrReq2;
  assign rd_req[3]  = iLNxtAddrReq3;
  assign rd_req[4]  = iDropAddrVld;
  assign rd_addr[0] = iLaddr0;
  assign rd_addr[1] = iLaddr1;
  assign rd_addr[2] = iLaddr2;
  assign rd_addr[3] = iLaddr3;
  assign rd_addr[4] = iDropAddr;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign lu_data[g] = live[lu_addr[g]] ? mem[lu_addr[g]] : '0;

    link_list_rd_port #(.WIDTH(ADDR_LENTH)) u_rd (
      .clk         (iClk),
      .resetn      (iRst_n),
      .req         (rd_req[g]),
      .addr        (rd_addr[g]),
      .lookup_addr (lu_addr[g]),
      .lookup_data (lu_data[g]),
      .data        (rd_data[g]),
      .vld         (rd_vld[g])
    );
  end

  assign oLdata0      = rd_data[0];
  assign oLdataVld0   = rd_vld[0];
  assign oLdata1      = rd_data[1];
  assign oLdataVld1   = rd_vld[1];
  assign oLdata2      = rd_data[2];
  assign oLdataVld2   = rd_vld[2];
  assign oLdata3      = rd_data[3];
  assign oLdataVld3   = rd_vld[3];
  assign oDropData    = rd_data[4];
  assign oDropDataVld = rd_vld[4];

endmodule

// File: tb/tb_link_list_sram.sv
// tb/tb_link_list_sram.sv - scoreboard bench for the next-pointer store
module tb_link_list_sram;
  import link_list_sram_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wv [4];
  cell_addr_t wa [4];
  cell_addr_t wd [4];
  logic       rq [5];
  cell_addr_t ra [5];
  cell_addr_t od [5];
  logic       ov [5];

  int total = 0;
  int bad   = 0;

  cell_addr_t ref_mem [4096];
  cell_addr_t exp_q [5][$];
  cell_addr_t last_data [5];

  always #5 clk = ~clk;

  link_list_sram dut (
    .iClk(clk), .iRst_n(rstn),
    .iWriteLdata0(wd[0]), .iWriteLaddr0(wa[0]), .iWriteLaddrVld0(wv[0]),
    .iWriteLdata1(wd[1]), .iWriteLaddr1(wa[1]), .iWriteLaddrVld1(wv[1]),
    .iWriteLdata2(wd[2]), .iWriteLaddr2(wa[2]), .iWriteLaddrVld2(wv[2]),
    .iWriteLdata3(wd[3]), .iWriteLaddr3(wa[3]), .iWriteLaddrVld3(wv[3]),
    .oLdata0(od[0]), .oLdataVld0(ov[0]), .iLaddr0(ra[0]), .iLNxtAddrReq0(rq[0]),
    .oLdata1(od[1]), .oLdataVld1(ov[1]), .iLaddr1(ra[1]), .iLNxtAddrReq1(rq[1]),
    .oLdata2(od[2]), .oLdataVld2(ov[2]), .iLaddr2(ra[2]), .iLNxtAddrReq2(rq[2]),
    .oLdata3(od[3]), .oLdataVld3(ov[3]), .iLaddr3(ra[3]), .iLNxtAddrReq3(rq[3]),
    .iDropAddr(ra[4]), .iDropAddrVld(rq[4]),
    .oDropData(od[4]), .oDropDataVld(ov[4])
  );

  function automatic void chk(string name, int p, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s port%0d: got 0x%0h expected 0x%0h at %0t", name, p, act, exp, $time);
    end
  endfunction

  task automatic clear_inputs();
    for (int p = 0; p < 4; p++) begin
      wv[p] = 1'b0; wa[p] = '0; wd[p] = '0;
    end
    for (int p = 0; p < 5; p++) begin
      rq[p] = 1'b0; ra[p] = '0;
    end
  endtask

  // Record what the coming edge should do, then let it happen.
  task automatic cycle();
    if (!rstn) begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
      for (int p = 0; p < 5; p++) begin
        last_data[p] = '0;
        exp_q[p].delete();
      end
    end else begin
      for (int p = 0; p < 5; p++)
        if (rq[p]) exp_q[p].push_back(ref_mem[ra[p]]);
      for (int p = 3; p >= 0; p--)
        if (wv[p]) ref_mem[wa[p]] = wd[p];
    end
    @(negedge clk);
  endtask

  // Monitor: compare each read port just after every edge.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < 5; p++) begin
      if (exp_q[p].size() > 0) begin
        cell_addr_t e;
        e = exp_q[p].pop_front();
        chk("vld_after_req", p, int'(ov[p]), 1);
        chk("data", p, int'(od[p]), int'(e));
        last_data[p] = e;
      end else begin
        chk("vld_idle", p, int'(ov[p]), 0);
        chk("data_hold", p, int'(od[p]), int'(last_data[p]));
      end
    end
  end

  initial begin
    rstn = 1'b0;
    clear_inputs();
    for (int p = 0; p < 5; p++) last_data[p] = '0;
    @(negedge clk);

    // reads issued during reset must not produce valid
    rq[2] = 1'b1; ra[2] = 12'h123;
    cycle();
    cycle();
    rstn = 1'b1;
    cycle();
    cycle();
    clear_inputs();
    cycle();

    // parallel writes, one strobe every 17 cycles
    for (int b = 0; b < 1024; b++) begin
      for (int k = 0; k < 4; k++) begin
        wv[k] = 1'b1; wa[k] = cell_addr_t'(4 * b + k); wd[k] = cell_addr_t'(4 * b + k);
      end
      cycle();
      clear_inputs();
      repeat (16) cycle();
    end
    for (int i = 0; i < 1024; i++) begin
      for (int k = 0; k < 4; k++) begin
        rq[k] = 1'b1; ra[k] = cell_addr_t'(4 * i + k);
      end
      cycle();
    end
    clear_inputs();
    cycle();

    // held request on port 0
    rq[0] = 1'b1; ra[0] = 12'd8;  cycle();
    ra[0] = 12'd12; cycle();
    ra[0] = 12'd16; cycle();
    clear_inputs(); cycle(); cycle();

    // write collision: port 0 wins over port 3
    wv[0] = 1'b1; wa[0] = 12'h050; wd[0] = 12'h111;
    wv[3] = 1'b1; wa[3] = 12'h050; wd[3] = 12'h333;
    cycle();
    clear_inputs();
    rq[1] = 1'b1; ra[1] = 12'h050; cycle();
    clear_inputs(); cycle();

    // read-before-write
    wv[0] = 1'b1; wa[0] = 12'h010; wd[0] = 12'hABC;
    rq[1] = 1'b1; ra[1] = 12'h010; cycle();
    wv[0] = 1'b0; cycle();
    clear_inputs(); cycle();

    // drop port alongside four egress reads
    wv[2] = 1'b1; wa[2] = 12'hFFF; wd[2] = 12'h7E5; cycle();
    clear_inputs();
    rq[4] = 1'b1; ra[4] = 12'hFFF;
    for (int k = 0; k < 4; k++) begin
      rq[k] = 1'b1; ra[k] = cell_addr_t'($urandom_range(0, 4095));
    end
    cycle();
    clear_inputs(); cycle();

    // randomized traffic on a narrow address window, with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 299) != 0);
      for (int p = 0; p < 4; p++) begin
        wv[p] = 1'($urandom_range(0, 1));
        wa[p] = cell_addr_t'($urandom_range(0, 15));
        wd[p] = cell_addr_t'($urandom);
      end
      for (int p = 0; p < 5; p++) begin
        rq[p] = 1'($urandom_range(0, 1));
        ra[p] = cell_addr_t'($urandom_range(0, 15));
      end
      cycle();
    end
    rstn = 1'b1;
    clear_inputs();
    cycle(); cycle();

    for (int p = 0; p < 5; p++)
      chk("queue_drained", p, exp_q[p].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
